// File: rtl/store_buffer.sv
// Purpose : DEPTH-entry circular store buffer between the EX/MEM stage and data memory.
//           Stores are written back in arrival order, and loads are forwarded from the youngest matching entry.
// Latency : a store can reach mem_wr one cycle after st_valid at the earliest.
//           ld_hit and ld_data are combinational from the buffer contents that were registered before this cycle.
// Backpr. : while full=1, any st_valid is dropped, so upstream must stall on full.
//           mem_busy=1 holds the head in place.
//
// Ports:
//   clk, rst             rising-edge clock; synchronous active-high reset
//   st_valid/addr/data   store request (enqueue when not full)
//   ld_valid/addr        load lookup; ld_hit/ld_data are the forwarding result
//   mem_busy             memory cannot accept a write this cycle
//   mem_addr/wdata/wr    head-entry write port to data memory
//   full/empty/count     occupancy status, all derived from registered count
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  input  logic                     mem_busy,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     mem_wr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage and control state
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic enq;
  logic drain;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Writes to memory are never issued during reset. This also covers entries
  // that reset is about to discard.
  assign drain  = !empty && !mem_busy && !rst;
  assign mem_wr = drain;

  // A store that arrives while full is dropped, even if a drain in the same
  // cycle frees a slot. This keeps the accept decision independent of mem_busy.
  assign enq = st_valid && !full && !rst;

  assign mem_addr  = empty ? 32'd0 : addr_q[head_q];
  assign mem_wdata = empty ? 32'd0 : data_q[head_q];

  // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 through
  // ordinary modulo-2^PW arithmetic.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (enq) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      tail_d         = tail_q + PW'(1);
    end
    if (drain) begin
      head_d = head_q + PW'(1);
    end

    case ({enq, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Forwarding. The loop walks the occupied slots from oldest (head) to
  // youngest, so the last match it finds is the youngest one. The slot that is
  // draining this cycle is still counted as occupied, so it can still hit. A
  // store being enqueued in this cycle is not in the array yet, so it is never
  // forwarded. Only the word index [11:2] takes part in the comparison.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    ld_hit  = 1'b0;
    ld_data = 32'd0;
    if (ld_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if ((CW'(i) < count_q) && (addr_q[idx][11:2] == ld_addr[11:2])) begin
          ld_hit  = 1'b1;
          ld_data = data_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // The payload needs no reset. Slots outside [head, head+count) are never
  // observed, and enq is already held low during reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        mem_busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        full;
  logic        empty;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .mem_busy(mem_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .ld_hit(ld_hit), .ld_data(ld_data),
    .full(full), .empty(empty), .count(count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of pending stores, oldest first.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];
  ent_t dut_log[$];

  // Compare every DUT output against the model for the current inputs.
  task automatic check_model(string tag);
    int          n;
    logic        e_wr;
    logic        e_hit;
    logic [31:0] e_ld;
    n     = mq.size();
    e_wr  = !rst && (n > 0) && !mem_busy;
    e_hit = 1'b0;
    e_ld  = 32'd0;
    if (ld_valid) begin
      for (int j = n - 1; j >= 0; j--) begin
        if (!e_hit && (mq[j].a[11:2] == ld_addr[11:2])) begin
          e_hit = 1'b1;
          e_ld  = mq[j].d;
        end
      end
    end
    check({tag, " mem_wr"},    mem_wr,    e_wr);
    check({tag, " mem_addr"},  mem_addr,  (n > 0) ? mq[0].a : 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, (n > 0) ? mq[0].d : 32'd0);
    check({tag, " ld_hit"},    ld_hit,    e_hit);
    check({tag, " ld_data"},   ld_data,   e_ld);
    check({tag, " full"},      full,      n == DEPTH);
    check({tag, " empty"},     empty,     n == 0);
    check({tag, " count"},     count,     n);
  endtask

  // Apply the effect of one clock edge to the model.
  task automatic update_model();
    int   n;
    logic wr;
    n  = mq.size();
    wr = !rst && (n > 0) && !mem_busy;
    if (rst) begin
      mq.delete();
    end else begin
      if (wr) mq.pop_front();
      if (st_valid && (n < DEPTH)) mq.push_back('{a: st_addr, d: st_data});
    end
  endtask

  // One cycle. Inputs were driven just after the previous rising edge. The
  // outputs are sampled on the falling edge, and the model steps on the rising edge.
  task automatic run_cycle(string tag);
    @(negedge clk);
    check_model(tag);
    if (mem_wr) dut_log.push_back('{a: mem_addr, d: mem_wdata});
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drive(logic r, logic sv, logic [31:0] sa, logic [31:0] sd,
                       logic lv, logic [31:0] la, logic b);
    rst = r; st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; mem_busy = b;
  endtask

  // Directed vectors. Each row holds the inputs for one cycle and the outputs
  // expected during that cycle, before its rising edge.
  typedef struct {
    logic        r, sv;
    logic [31:0] sa, sd;
    logic        lv;
    logic [31:0] la;
    logic        b;
    logic        wr;
    logic [31:0] ma, md;
    logic        hit;
    logic [31:0] ld;
    logic        fl, em;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic sv, logic [31:0] sa, logic [31:0] sd,
                              logic lv, logic [31:0] la, logic b,
                              logic wr, logic [31:0] ma, logic [31:0] md,
                              logic hit, logic [31:0] ld, logic fl, logic em, int cnt);
    vec_t v;
    v.r = r; v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la; v.b = b;
    v.wr = wr; v.ma = ma; v.md = md; v.hit = hit; v.ld = ld;
    v.fl = fl; v.em = em; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl[$];
  ent_t sent[$];

  initial begin
    //                  rst sv  st_addr   st_data       lv  ld_addr   busy  wr  mem_addr  mem_wdata     hit ld_data full empty cnt
    tbl.push_back(mk(1, 0, 32'h0,    32'h0,        0, 32'h0,    0,   0, 32'h0,    32'h0,        0, 32'h0, 0, 1, 0));
    // single store to 0x10
    tbl.push_back(mk(0, 1, 32'h10,   32'hAABBCCDD, 0, 32'h0,    0,   0, 32'h0,    32'h0,        0, 32'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        0, 32'h0,    0,   1, 32'h10,   32'hAABBCCDD, 0, 32'h0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        0, 32'h0,    0,   0, 32'h0,    32'h0,        0, 32'h0, 0, 1, 0));
    // youngest-match forwarding while memory is busy
    tbl.push_back(mk(0, 1, 32'h40,   32'h1,        0, 32'h0,    1,   0, 32'h0,    32'h0,        0, 32'h0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h44,   32'h2,        0, 32'h0,    1,   0, 32'h40,   32'h1,        0, 32'h0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 32'h40,   32'h3,        0, 32'h0,    1,   0, 32'h40,   32'h1,        0, 32'h0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        1, 32'h40,   1,   0, 32'h40,   32'h1,        1, 32'h3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        1, 32'h48,   1,   0, 32'h40,   32'h1,        0, 32'h0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        1, 32'h1040, 1,   0, 32'h40,   32'h1,        1, 32'h3, 0, 0, 3));
    // a same-cycle store to 0x44 must not be forwarded to the load
    tbl.push_back(mk(0, 1, 32'h44,   32'h9,        1, 32'h44,   1,   0, 32'h40,   32'h1,        1, 32'h2, 0, 0, 3));
    // full: the store is dropped
    tbl.push_back(mk(0, 1, 32'h20,   32'h5,        1, 32'h20,   1,   0, 32'h40,   32'h1,        0, 32'h0, 1, 0, 4));
    // full with a drain in the same cycle: the store is still dropped
    tbl.push_back(mk(0, 1, 32'h24,   32'h6,        1, 32'h44,   0,   1, 32'h40,   32'h1,        1, 32'h9, 1, 0, 4));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        1, 32'h48,   0,   1, 32'h44,   32'h2,        0, 32'h0, 0, 0, 3));
    // the entry draining this cycle still hits
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        1, 32'h40,   0,   1, 32'h40,   32'h3,        1, 32'h3, 0, 0, 2));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        0, 32'h0,    0,   1, 32'h44,   32'h9,        0, 32'h0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        0, 32'h0,    0,   0, 32'h0,    32'h0,        0, 32'h0, 0, 1, 0));
    // same-cycle store and load to 0x80 with an empty buffer
    tbl.push_back(mk(0, 1, 32'h80,   32'h55,       1, 32'h80,   0,   0, 32'h0,    32'h0,        0, 32'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        1, 32'h80,   0,   1, 32'h80,   32'h55,       1, 32'h55, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        0, 32'h0,    0,   0, 32'h0,    32'h0,        0, 32'h0, 0, 1, 0));
    // reset while holding 3 entries: no write during or after it
    tbl.push_back(mk(0, 1, 32'h100,  32'hA,        0, 32'h0,    1,   0, 32'h0,    32'h0,        0, 32'h0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h104,  32'hB,        0, 32'h0,    1,   0, 32'h100,  32'hA,        0, 32'h0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 32'h108,  32'hC,        0, 32'h0,    1,   0, 32'h100,  32'hA,        0, 32'h0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 32'h0,    32'h0,        0, 32'h0,    0,   0, 32'h100,  32'hA,        0, 32'h0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        0, 32'h0,    0,   0, 32'h0,    32'h0,        0, 32'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,        0, 32'h0,    0,   0, 32'h0,    32'h0,        0, 32'h0, 0, 1, 0));

    // Initial reset. State is unknown before the first reset edge, so these
    // cycles are not checked.
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    mq.delete();

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lv, tbl[i].la, tbl[i].b);
      @(negedge clk);
      check($sformatf("row%0d mem_wr", i),    mem_wr,    tbl[i].wr);
      check($sformatf("row%0d mem_addr", i),  mem_addr,  tbl[i].ma);
      check($sformatf("row%0d mem_wdata", i), mem_wdata, tbl[i].md);
      check($sformatf("row%0d ld_hit", i),    ld_hit,    tbl[i].hit);
      check($sformatf("row%0d ld_data", i),   ld_data,   tbl[i].ld);
      check($sformatf("row%0d full", i),      full,      tbl[i].fl);
      check($sformatf("row%0d empty", i),     empty,     tbl[i].em);
      check($sformatf("row%0d count", i),     count,     tbl[i].cnt);
      @(posedge clk);
      update_model();
      #1;
    end

    // Enqueue and drain in the same cycle at count=2: occupancy stays at 2.
    drive(0, 1, 32'h300, 32'h31, 0, 0, 1); run_cycle("ed0");
    drive(0, 1, 32'h304, 32'h32, 0, 0, 1); run_cycle("ed1");
    drive(0, 1, 32'h308, 32'h33, 0, 0, 0); run_cycle("ed2");
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("enq_drain count", count, 2);
    @(posedge clk); update_model(); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) run_cycle("ed_flush");

    // Pointer wrap-around: 3*DEPTH+1 back-to-back stores, each one checked on
    // its way out to memory.
    dut_log.delete();
    sent.delete();
    for (int k = 0; k < 3 * DEPTH + 1; k++) begin
      drive(0, 1, 32'h200 + 32'(k) * 4, 32'hC0DE0000 | 32'(k), 0, 0, 0);
      sent.push_back('{a: st_addr, d: st_data});
      run_cycle($sformatf("wrap%0d", k));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) run_cycle("wrap_flush");
    check("wrap write count", dut_log.size(), sent.size());
    for (int k = 0; k < sent.size(); k++) begin
      if (k < dut_log.size()) begin
        check($sformatf("wrap order addr%0d", k), dut_log[k].a, sent[k].a);
        check($sformatf("wrap order data%0d", k), dut_log[k].d, sent[k].d);
      end
    end

    // Reset while busy with 3 entries: nothing is written after busy drops.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h400 + 32'(k) * 4, 32'(k), 0, 0, 1);
      run_cycle("rb_fill");
    end
    drive(1, 1, 32'h500, 32'h77, 1, 32'h400, 1); run_cycle("rb_rst");
    drive(0, 0, 0, 0, 0, 0, 0);
    dut_log.delete();
    repeat (3) run_cycle("rb_after");
    check("reset discard writes", dut_log.size(), 0);

    // Random traffic over a small set of word indices, so that loads hit often
    // and upper-bit aliasing also gets exercised.
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 59) == 0),
            $urandom_range(0, 1),
            ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2),
            $urandom,
            $urandom_range(0, 1),
            ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2),
            ($urandom_range(0, 99) < 40));
      run_cycle($sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
